// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_pkg
//  Purpose  : Shared types and constants for the I2C target.
//             - slave_state_e : byte/bit-phase state of the target FSM
//             - I2C_ACK/NACK  : SDA level meaning acknowledge / not-acknowledge
//             - BIT_CNT_INIT  : bit counter value at the start of every byte
//  Revision : 1.0  initial release
// ============================================================================
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    RX       = 3'd3,
    RX_ACK   = 3'd4,
    TX       = 3'd5,
    TX_ACK   = 3'd6
  } slave_state_e;

  localparam logic       I2C_ACK      = 1'b0;
  localparam logic       I2C_NACK     = 1'b1;
  localparam logic [2:0] BIT_CNT_INIT = 3'd7;

endpackage : i2c_pkg
`default_nettype wire

// File: rtl/i2c_in_filter.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_in_filter
//  Purpose  : Conditions one raw I2C pad input. Two-flop synchronizer followed
//             by a stability filter: the filtered level only follows the
//             synchronized input once it has held a new value for FILT_LEN
//             clocks. Rise/fall strobes are asserted in the same cycle the
//             filtered level changes. Pad-to-strobe latency is 2+FILT_LEN clk.
//  Ports    : clk     in   system clock
//             rst_n   in   asynchronous active-low reset
//             pad_i   in   raw pad level
//             level_o out  filtered level (resets to 1 = idle bus)
//             rise_o  out  one-cycle strobe, filtered level went 0->1
//             fall_o  out  one-cycle strobe, filtered level went 1->0
//  Revision : 1.0  initial release
// ============================================================================
module i2c_in_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             rise_q,  rise_d;
  logic             fall_q,  fall_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // The counter measures how long the synchronized input has disagreed with
  // the filtered level; any return to agreement restarts the measurement.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
        fall_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pad_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule : i2c_in_filter
`default_nettype wire

// File: rtl/i2c_slave.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_slave
//  Purpose  : I2C target with a fixed 7-bit address and a byte-level user
//             interface. SCL/SDA are oversampled on clk (>= 20x SCL), START,
//             repeated START and STOP are detected from the filtered lines.
//             SDA is open-drain: sda_t=1 releases, sda_t=0 drives sda_o (0).
//  Ports    : clk, rst_n         clock, asynchronous active-low reset
//             scl_i, sda_i       raw pad inputs
//             sda_o, sda_t       SDA drive value (always 0) / tristate enable
//             ack_en             1 = ACK received data bytes, 0 = NACK them
//             rx_data, rx_valid  last written byte and its one-cycle strobe
//             tx_data, tx_req    read byte; captured in the cycle tx_req is 1
//             addressed          high from address ACK to STOP/START/NACK
//             start_det          one-cycle pulse on START or repeated START
//             stop_det           one-cycle pulse on STOP
//             tx_done            one-cycle pulse when the master NACKs a read
//  Revision : 1.0  initial release
// ============================================================================
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         FILT_LEN   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_t,
  input  logic       ack_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       addressed,
  output logic       start_det,
  output logic       stop_det,
  output logic       tx_done
);

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic w_scl_lvl, w_scl_rise, w_scl_fall;
  logic w_sda_lvl, w_sda_rise, w_sda_fall;

  i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk     (clk),
    .rst_n   (rst_n),
    .pad_i   (scl_i),
    .level_o (w_scl_lvl),
    .rise_o  (w_scl_rise),
    .fall_o  (w_scl_fall)
  );

  i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk     (clk),
    .rst_n   (rst_n),
    .pad_i   (sda_i),
    .level_o (w_sda_lvl),
    .rise_o  (w_sda_rise),
    .fall_o  (w_sda_fall)
  );

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  slave_state_e state_q, state_d;
  logic [2:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]   shift_q,   shift_d;
  logic         byte_done_q, byte_done_d;  // 8 bits in, waiting for SCL fall
  logic         rw_q,      rw_d;
  logic         mack_q,    mack_d;         // master ACKed the last read byte
  logic         sda_t_q,   sda_t_d;
  logic         addressed_q, addressed_d;
  logic [7:0]   rx_data_q, rx_data_d;
  logic         rx_valid_q, rx_valid_d;
  logic         start_det_q, start_det_d;
  logic         stop_det_q,  stop_det_d;
  logic         tx_done_q,   tx_done_d;

  logic       w_start, w_stop, w_tx_load;
  logic [7:0] w_shift_in;

  // Bus conditions: SDA moving while SCL is high. They override any bit
  // strobe arriving in the same cycle.
  assign w_start    = w_sda_fall & w_scl_lvl;
  assign w_stop     = w_sda_rise & w_scl_lvl;
  assign w_shift_in = {shift_q[6:0], w_sda_lvl};

  // A read byte is fetched on the SCL fall that closes either the address
  // ACK of a read or a master-ACKed data byte. tx_req is combinational so
  // tx_data is captured in exactly the cycle tx_req is asserted.
  assign w_tx_load = ~w_start & ~w_stop & w_scl_fall &
                     (((state_q == ADDR_ACK) & rw_q) |
                      ((state_q == TX_ACK)   & mack_q));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= BIT_CNT_INIT;
      shift_q     <= 8'h00;
      byte_done_q <= 1'b0;
      rw_q        <= 1'b0;
      mack_q      <= 1'b0;
      sda_t_q     <= 1'b1;
      addressed_q <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      byte_done_q <= byte_done_d;
      rw_q        <= rw_d;
      mack_q      <= mack_d;
      sda_t_q     <= sda_t_d;
      addressed_q <= addressed_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      start_det_q <= start_det_d;
      stop_det_q  <= stop_det_d;
      tx_done_q   <= tx_done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_done_d = byte_done_q;
    rw_d        = rw_q;
    mack_d      = mack_q;
    sda_t_d     = sda_t_q;
    addressed_d = addressed_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    start_det_d = 1'b0;
    stop_det_d  = 1'b0;
    tx_done_d   = 1'b0;

    if (w_start) begin
      state_d     = ADDR;
      bit_cnt_d   = BIT_CNT_INIT;
      byte_done_d = 1'b0;
      mack_d      = 1'b0;
      sda_t_d     = 1'b1;
      addressed_d = 1'b0;
      start_det_d = 1'b1;
    end else if (w_stop) begin
      state_d     = IDLE;
      byte_done_d = 1'b0;
      mack_d      = 1'b0;
      sda_t_d     = 1'b1;
      addressed_d = 1'b0;
      stop_det_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: ;

        ADDR: begin
          if (w_scl_rise && !byte_done_q) begin
            shift_d   = w_shift_in;
            bit_cnt_d = bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) begin
              if (w_shift_in[7:1] == SLAVE_ADDR) byte_done_d = 1'b1;
              else                               state_d     = IDLE;
            end
          end else if (w_scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            rw_d        = shift_q[0];
            sda_t_d     = I2C_ACK;
            state_d     = ADDR_ACK;
          end
        end

        ADDR_ACK: begin
          if (w_scl_fall) begin
            addressed_d = 1'b1;
            bit_cnt_d   = BIT_CNT_INIT;
            if (rw_q) begin
              shift_d = tx_data;
              sda_t_d = tx_data[7];
              state_d = TX;
            end else begin
              sda_t_d = 1'b1;
              state_d = RX;
            end
          end
        end

        RX: begin
          if (w_scl_rise && !byte_done_q) begin
            shift_d   = w_shift_in;
            bit_cnt_d = bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) begin
              rx_data_d   = w_shift_in;
              rx_valid_d  = 1'b1;
              byte_done_d = 1'b1;
            end
          end else if (w_scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            sda_t_d     = ack_en ? I2C_ACK : I2C_NACK;
            state_d     = RX_ACK;
          end
        end

        RX_ACK: begin
          if (w_scl_fall) begin
            sda_t_d   = 1'b1;
            bit_cnt_d = BIT_CNT_INIT;
            state_d   = RX;
          end
        end

        // bit_cnt here counts bits still to be presented after the current one.
        TX: begin
          if (w_scl_fall) begin
            if (bit_cnt_q == 3'd0) begin
              sda_t_d = 1'b1;
              state_d = TX_ACK;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_t_d   = shift_q[6];
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end
        end

        TX_ACK: begin
          if (w_scl_rise) begin
            if (w_sda_lvl == I2C_NACK) begin
              tx_done_d   = 1'b1;
              addressed_d = 1'b0;
              state_d     = IDLE;
            end else begin
              mack_d = 1'b1;
            end
          end else if (w_tx_load) begin
            mack_d    = 1'b0;
            shift_d   = tx_data;
            sda_t_d   = tx_data[7];
            bit_cnt_d = BIT_CNT_INIT;
            state_d   = TX;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    sda_o     = 1'b0;
    sda_t     = sda_t_q;
    rx_data   = rx_data_q;
    rx_valid  = rx_valid_q;
    tx_req    = w_tx_load;
    addressed = addressed_q;
    start_det = start_det_q;
    stop_det  = stop_det_q;
    tx_done   = tx_done_q;
  end

endmodule : i2c_slave
`default_nettype wire

// File: tb/tb_i2c_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_slave
//  Purpose  : Directed bench for i2c_slave. A bit-banged master drives SCL/SDA
//             (SCL period 100 clk); received write bytes and read bytes are
//             checked against scoreboard queues, pulse outputs are counted.
//  Revision : 1.0  initial release
// ============================================================================
module tb_i2c_slave;

  localparam int Q = 25;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       ack_en = 1'b1;
  logic [7:0] tx_data = 8'h00;

  logic       sda_o, sda_t, rx_valid, tx_req, addressed, start_det, stop_det, tx_done;
  logic [7:0] rx_data;
  logic       sda_line;

  // Open-drain wired-AND of master and target.
  assign sda_line = sda_m & (sda_t | sda_o);

  i2c_slave #(.SLAVE_ADDR(7'h50), .FILT_LEN(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_m),
    .sda_i     (sda_line),
    .sda_o     (sda_o),
    .sda_t     (sda_t),
    .ack_en    (ack_en),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_req    (tx_req),
    .addressed (addressed),
    .start_det (start_det),
    .stop_det  (stop_det),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int n_start = 0, n_stop = 0, n_txreq = 0, n_txdone = 0, n_rx = 0, n_low = 0;
  logic [7:0] rx_exp[$];
  logic [7:0] tx_exp[$];
  logic t_prev = 1'b1, rst_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse counters, rx scoreboard, and SDA-change-while-SCL-high monitor.
  always @(negedge clk) begin
    if (start_det) n_start++;
    if (stop_det)  n_stop++;
    if (tx_req)    n_txreq++;
    if (tx_done)   n_txdone++;
    if (!sda_t)    n_low++;
    if (rx_valid) begin
      n_rx++;
      if (rx_exp.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
      else                    check("rx_data_sb", rx_data, rx_exp.pop_front());
    end
    if (rst_n && rst_prev && (sda_t !== t_prev)) check("sda_t_change_scl_low", scl_m, 32'd0);
    t_prev   = sda_t;
    rst_prev = rst_n;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(2*Q);
    sda_m = 1'b0; wait_clk(2*Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(2*Q);
    sda_m = 1'b1; wait_clk(2*Q);
  endtask

  task automatic put_bit(input logic b, input bit glitch);
    sda_m = b; wait_clk(Q);
    scl_m = 1'b1;
    if (glitch) begin
      wait_clk(Q); scl_m = 1'b0; wait_clk(2); scl_m = 1'b1; wait_clk(Q-2);
    end else begin
      wait_clk(2*Q);
    end
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic get_bit(output logic b, output logic t);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    b = sda_line; t = sda_t;
    wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic put_byte(input logic [7:0] v, input int glitch_bit);
    for (int i = 7; i >= 0; i--) put_bit(v[i], i == glitch_bit);
  endtask

  task automatic get_byte(output logic [7:0] v);
    logic t;
    for (int i = 7; i >= 0; i--) get_bit(v[i], t);
  endtask

  initial begin
    logic b, t;
    logic [7:0] v;
    int s0, p0, r0, q0, d0, l0;

    // ---- reset state ----
    wait_clk(5);
    check("rst_sda_t", sda_t, 1);
    check("rst_sda_o", sda_o, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_req", tx_req, 0);
    check("rst_addressed", addressed, 0);
    check("rst_start_det", start_det, 0);
    check("rst_stop_det", stop_det, 0);
    check("rst_tx_done", tx_done, 0);
    rst_n = 1'b1;
    wait_clk(10);

    // ---- write 0xA5 to 0x50 ----
    s0 = n_start; p0 = n_stop; r0 = n_rx;
    bus_start();
    put_byte(8'hA0, -1);
    get_bit(b, t);
    check("wr_addr_ack_line", b, 0);
    check("wr_addr_ack_t", t, 0);
    check("wr_addressed", addressed, 1);
    rx_exp.push_back(8'hA5);
    put_byte(8'hA5, -1);
    get_bit(b, t);
    check("wr_data_ack_t", t, 0);
    check("wr_rx_data", rx_data, 8'hA5);
    bus_stop();
    check("wr_addressed_after_stop", addressed, 0);
    check("wr_rx_pulses", n_rx - r0, 1);
    check("wr_start_pulses", n_start - s0, 1);
    check("wr_stop_pulses", n_stop - p0, 1);

    // ---- address mismatch ----
    l0 = n_low; r0 = n_rx;
    bus_start();
    put_byte(8'hA2, -1);
    get_bit(b, t);
    check("mm_addr_line", b, 1);
    put_byte(8'hFF, -1);
    get_bit(b, t);
    bus_stop();
    check("mm_sda_never_low", n_low - l0, 0);
    check("mm_rx_pulses", n_rx - r0, 0);
    check("mm_addressed", addressed, 0);

    // ---- read two bytes ----
    q0 = n_txreq; d0 = n_txdone;
    tx_exp.push_back(8'h3C);
    tx_exp.push_back(8'hC3);
    tx_data = 8'h3C;
    bus_start();
    put_byte(8'hA1, -1);
    get_bit(b, t);
    check("rd_addr_ack_t", t, 0);
    get_byte(v);
    check("rd_byte1", v, tx_exp.pop_front());
    check("rd_txreq_after_byte1", n_txreq - q0, 1);
    tx_data = 8'hC3;
    put_bit(1'b0, 1'b0);
    get_byte(v);
    check("rd_byte2", v, tx_exp.pop_front());
    put_bit(1'b1, 1'b0);
    check("rd_tx_done_pulses", n_txdone - d0, 1);
    check("rd_txreq_total", n_txreq - q0, 2);
    check("rd_sda_released", sda_t, 1);
    check("rd_addressed_after_nack", addressed, 0);
    bus_stop();

    // ---- repeated START after partial write byte ----
    s0 = n_start; r0 = n_rx; q0 = n_txreq;
    bus_start();
    put_byte(8'hA0, -1);
    get_bit(b, t);
    check("rs_addr_ack_t", t, 0);
    put_bit(1'b1, 1'b0); put_bit(1'b0, 1'b0); put_bit(1'b1, 1'b0); put_bit(1'b1, 1'b0);
    bus_start();
    check("rs_addressed_cleared", addressed, 0);
    put_byte(8'hA1, -1);
    tx_exp.push_back(8'h96);
    tx_data = 8'h96;
    get_bit(b, t);
    check("rs_read_ack_t", t, 0);
    get_byte(v);
    check("rs_read_byte", v, tx_exp.pop_front());
    put_bit(1'b1, 1'b0);
    bus_stop();
    check("rs_start_pulses", n_start - s0, 2);
    check("rs_txreq_pulses", n_txreq - q0, 1);
    check("rs_no_partial_rx", n_rx - r0, 0);

    // ---- SCL glitch, then NACKed byte ----
    r0 = n_rx;
    ack_en = 1'b1;
    bus_start();
    put_byte(8'hA0, -1);
    get_bit(b, t);
    rx_exp.push_back(8'h5A);
    put_byte(8'h5A, 4);
    get_bit(b, t);
    check("gl_ack_t", t, 0);
    check("gl_rx_data", rx_data, 8'h5A);
    ack_en = 1'b0;
    rx_exp.push_back(8'h81);
    put_byte(8'h81, -1);
    get_bit(b, t);
    check("nk_nack_t", t, 1);
    check("nk_nack_line", b, 1);
    check("nk_rx_data", rx_data, 8'h81);
    check("nk_rx_pulses", n_rx - r0, 2);
    bus_stop();
    ack_en = 1'b1;

    // ---- reset during address ACK ----
    bus_start();
    put_byte(8'hA0, -1);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    check("ra_pre_reset_t", sda_t, 0);
    #2 rst_n = 1'b0;
    #1 check("ra_async_release", sda_t, 1);
    check("ra_addressed", addressed, 0);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
    l0 = n_low;
    put_byte(8'hA0, -1);
    get_bit(b, t);
    put_byte(8'h55, -1);
    get_bit(b, t);
    check("ra_ignored_no_drive", n_low - l0, 0);
    check("ra_ignored_addressed", addressed, 0);
    bus_stop();
    bus_start();
    put_byte(8'hA0, -1);
    get_bit(b, t);
    check("ra_fresh_start_ack", t, 0);
    bus_stop();

    // ---- scoreboards drained ----
    wait_clk(10);
    check("rx_scoreboard_empty", rx_exp.size(), 0);
    check("tx_scoreboard_empty", tx_exp.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_i2c_slave
`default_nettype wire
